// File: rtl/seg7_capture_if.sv
// Decoded-glyph stream leaving seg7_capture: head-of-FIFO data with valid/ready.
interface seg7_capture_if;
    logic [3:0] data;
    logic       blank;
    logic       valid;
    logic       ready;

    modport master (output data, output blank, output valid, input ready);
    modport slave  (input data, input blank, input valid, output ready);
endinterface

// File: rtl/seg7_capture.sv
// Samples a 7-segment display, captures each glyph once it has been stable,
// decodes it to a hex nibble or blank token and queues it in a small FIFO.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            segments,
    seg7_capture_if.master        stream,
    input  logic                  clear_err,
    output logic                  seg_err,
    output logic                  overflow
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [6:0]    samp;
    logic [CW-1:0] run_left;
    logic          captured;
    logic          fire;

    logic [3:0]    dec_data;
    logic          dec_hex;
    logic          dec_blank;
    logic          push_req;
    logic          bad_glyph;

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          valid;
    logic          pop;
    logic          push_ok;
    logic          drop;

    // run_left counts down to zero over a stable run; a run is captured once.
    assign fire = (run_left == '0) && !captured;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            samp     <= 7'h00;
            run_left <= CW'(STABLE_CYCLES);
            captured <= 1'b1;
        end else begin
            samp <= segments;
            if (segments != samp) begin
                run_left <= CW'(STABLE_CYCLES - 1);
                captured <= 1'b0;
            end else begin
                if (run_left != '0)
                    run_left <= run_left - 1'b1;
                if (fire)
                    captured <= 1'b1;
            end
        end
    end

    always_comb begin
        dec_data = 4'h0;
        dec_hex  = 1'b1;
        case (samp)
            7'h3F: dec_data = 4'h0;
            7'h06: dec_data = 4'h1;
            7'h5B: dec_data = 4'h2;
            7'h4F: dec_data = 4'h3;
            7'h66: dec_data = 4'h4;
            7'h6D: dec_data = 4'h5;
            7'h7D: dec_data = 4'h6;
            7'h07: dec_data = 4'h7;
            7'h7F: dec_data = 4'h8;
            7'h6F: dec_data = 4'h9;
            7'h77: dec_data = 4'hA;
            7'h7C: dec_data = 4'hB;
            7'h39: dec_data = 4'hC;
            7'h5E: dec_data = 4'hD;
            7'h79: dec_data = 4'hE;
            7'h71: dec_data = 4'hF;
            default: dec_hex = 1'b0;
        endcase
    end

    assign dec_blank = (samp == 7'h00);
    assign push_req  = fire && (dec_hex || dec_blank);
    assign bad_glyph = fire && !(dec_hex || dec_blank);

    assign full    = (count == (AW+1)'(FIFO_DEPTH));
    assign valid   = (count != '0);
    assign pop     = valid && stream.ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= {dec_blank, dec_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_err  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            seg_err  <= bad_glyph | (seg_err & ~clear_err);
            overflow <= drop | (overflow & ~clear_err);
        end
    end

    // Head is gated so stale storage never shows while the FIFO is empty.
    assign stream.valid = valid;
    assign stream.data  = valid ? mem[rd_ptr][3:0] : 4'h0;
    assign stream.blank = valid ? mem[rd_ptr][4]   : 1'b0;

endmodule
